// File: rtl/zbuf_pkg.sv
// Shared types for the z-buffer depth-test block: compare modes and control states.
package zbuf_pkg;

  typedef enum logic [1:0] {
    LESS   = 2'd0,
    LEQUAL = 2'd1,
    ALWAYS = 2'd2,
    NEVER  = 2'd3
  } cmp_mode_e;

  typedef enum logic [1:0] {
    INIT_CLR = 2'd0,
    IDLE     = 2'd1,
    DRAIN    = 2'd2,
    CLEAR    = 2'd3
  } zbuf_state_e;

endpackage

// File: rtl/zbuf_ram.sv
// Depth storage: one write port, three registered read ports that return the pre-write value on collision.
module zbuf_ram #(
  parameter int ADDR_W = 20,
  parameter int Z_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [Z_W-1:0]    wdata,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic [Z_W-1:0]    rd0_data,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [Z_W-1:0]    rd1_data,
  input  logic [ADDR_W-1:0] rdt_addr,
  output logic [Z_W-1:0]    rdt_data
);

  logic [Z_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // External read ports have a defined reset value; the test read port is pure data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd0_data <= '0;
      rd1_data <= '0;
    end else begin
      rd0_data <= mem[rd0_addr];
      rd1_data <= mem[rd1_addr];
    end
  end

  always_ff @(posedge clk) begin
    rdt_data <= mem[rdt_addr];
  end

endmodule

// File: rtl/zbuffer_depth_test.sv
// Z-buffer with a one-stage depth-test read-modify-write pipeline, two read ports and a clear sweep.
module zbuffer_depth_test
  import zbuf_pkg::*;
#(
  parameter int             ADDR_W    = 20,
  parameter int             Z_W       = 16,
  parameter logic [Z_W-1:0] CLEAR_VAL = {Z_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic [Z_W-1:0]    rd0_data,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [Z_W-1:0]    rd1_data,
  input  logic              clear_req,
  output logic              busy,
  input  logic [1:0]        cmp_mode,
  input  logic              tst_valid,
  output logic              tst_ready,
  input  logic [ADDR_W-1:0] tst_addr,
  input  logic [Z_W-1:0]    tst_z,
  output logic              res_valid,
  output logic              res_pass,
  output logic [ADDR_W-1:0] res_addr
);

  function automatic logic depth_pass(cmp_mode_e m, logic [Z_W-1:0] z, logic [Z_W-1:0] stored);
    case (m)
      LESS:    return z < stored;
      LEQUAL:  return z <= stored;
      ALWAYS:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  zbuf_state_e       state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              sweep, accept, last_clr;

  logic              vld_p1, fwd_p1, pass_p1, wr_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [Z_W-1:0]    z_p1, fwd_z_p1, ram_q_p1, stored_p1;
  cmp_mode_e         mode_p1;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [Z_W-1:0]    wdata;

  assign busy      = (state != IDLE);
  assign tst_ready = (state == IDLE) & ~clear_req;
  assign accept    = tst_valid & tst_ready;
  assign sweep     = (state == INIT_CLR) | (state == CLEAR);
  assign last_clr  = (clr_cnt == {ADDR_W{1'b1}});

  // Sweep and test writes never overlap: S1 is only ever valid outside the sweep states.
  always_comb begin
    we    = 1'b0;
    waddr = addr_p1;
    wdata = z_p1;
    if (sweep) begin
      we    = 1'b1;
      waddr = clr_cnt;
      wdata = CLEAR_VAL;
    end else if (wr_p1) begin
      we = 1'b1;
    end
  end

  zbuf_ram #(.ADDR_W(ADDR_W), .Z_W(Z_W)) u_ram (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .rd0_addr (rd0_addr),
    .rd0_data (rd0_data),
    .rd1_addr (rd1_addr),
    .rd1_data (rd1_data),
    .rdt_addr (tst_addr),
    .rdt_data (ram_q_p1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= INIT_CLR;
      clr_cnt <= '0;
    end else begin
      case (state)
        INIT_CLR, CLEAR: begin
          if (last_clr) begin
            state   <= IDLE;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
          end
        end
        IDLE:    if (clear_req) state <= DRAIN;
        DRAIN:   if (!vld_p1) state <= CLEAR;
        default: state <= IDLE;
      endcase
    end
  end

  // ---- S1: fragment registered alongside its RAM read ----
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p1  <= tst_addr;
      z_p1     <= tst_z;
      mode_p1  <= cmp_mode_e'(cmp_mode);
      fwd_z_p1 <= z_p1;
    end
  end

  // The RAM read taken on the same edge as an S1 write is stale, so that write is forwarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      fwd_p1 <= 1'b0;
    end else begin
      vld_p1 <= accept;
      fwd_p1 <= accept & wr_p1 & (tst_addr == addr_p1);
    end
  end

  assign stored_p1 = fwd_p1 ? fwd_z_p1 : ram_q_p1;
  assign pass_p1   = depth_pass(mode_p1, z_p1, stored_p1);
  assign wr_p1     = vld_p1 & pass_p1;

  // ---- S2: result strobe ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_pass  <= 1'b0;
      res_addr  <= '0;
    end else begin
      res_valid <= vld_p1;
      res_pass  <= wr_p1;
      if (vld_p1) res_addr <= addr_p1;
    end
  end

endmodule
